// File: rtl/clk_div_pkg.sv
// Shared types and width helper for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    DONE      = 2'd2
  } state_e;

  // Index of one of the two configuration requesters.
  typedef logic req_id_t;

  function automatic int DIV_W(input int max_div);
    return $clog2(max_div) + 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: half-period counter, output toggle, parking and
// glitch-free reload of the half-period at a boundary.
module clk_div_core #(
  parameter int W        = 9,
  parameter int INIT_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cur_div,
  output logic         clk_div,
  output logic         tick,
  output logic         fall,
  output logic         parked
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         clk_div_q, clk_div_d;
  logic         tick_q, tick_d;
  logic         at_end;

  assign at_end = (cnt_q == div_q);
  // A running high phase always completes, so parking only happens while low.
  assign parked = !enable && !clk_div_q;
  assign fall   = at_end && clk_div_q;

  always_comb begin
    cnt_d     = cnt_q + W'(1);
    div_d     = div_q;
    clk_div_d = clk_div_q;
    tick_d    = 1'b0;
    if (parked) begin
      cnt_d = W'(1);
    end else if (at_end) begin
      cnt_d     = W'(1);
      clk_div_d = ~clk_div_q;
      tick_d    = 1'b1;
    end
    // Only asserted on a falling boundary or while parked, so the new
    // half-period always starts from a fresh phase.
    if (load) begin
      div_d = load_val;
      cnt_d = W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= W'(1);
      div_q     <= W'(INIT_DIV);
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign cur_div = div_q;
  assign clk_div = clk_div_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_cfg_arb.sv
// Programmable clock divider with a two-requester round-robin configuration
// arbiter; new half-periods take effect only at a falling edge or while parked.
module clk_div_cfg_arb
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV  = 256,
  parameter int INIT_DIV = 2,
  parameter int W        = DIV_W(MAX_DIV)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   req,
  input  logic [W-1:0] div_in0,
  input  logic [W-1:0] div_in1,
  output logic [1:0]   ack,
  output logic         err,
  output logic         busy,
  output logic [W-1:0] cur_div,
  output logic         clk_div,
  output logic         tick
);

  localparam logic [W-1:0] MAX_V = W'(MAX_DIV);

  state_e       state_q, state_d;
  req_id_t      ptr_q, ptr_d;
  req_id_t      pid_q, pid_d;
  logic [W-1:0] pval_q, pval_d;
  logic [1:0]   ack_q, ack_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;

  req_id_t      gnt;
  logic [W-1:0] gval;
  logic         bad;
  logic         load;
  logic         fall;
  logic         parked;

  // Round robin: a lone request wins outright, a tie goes to the pointer side.
  always_comb begin
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = ptr_q;
    endcase
  end

  assign gval = gnt ? div_in1 : div_in0;
  assign bad  = (gval == '0) || (gval > MAX_V);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pid_d   = pid_q;
    pval_d  = pval_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          pid_d  = gnt;
          pval_d = gval;
          ptr_d  = ~gnt;
          if (bad) begin
            state_d    = DONE;
            ack_d[gnt] = 1'b1;
            err_d      = 1'b1;
          end else begin
            state_d = WAIT_EDGE;
          end
        end
      end
      WAIT_EDGE: begin
        if (fall || parked) begin
          load         = 1'b1;
          state_d      = DONE;
          ack_d[pid_q] = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      pid_q   <= 1'b0;
      pval_q  <= '0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pid_q   <= pid_d;
      pval_q  <= pval_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  clk_div_core #(
    .W        (W),
    .INIT_DIV (INIT_DIV)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .load_val (pval_q),
    .cur_div  (cur_div),
    .clk_div  (clk_div),
    .tick     (tick),
    .fall     (fall),
    .parked   (parked)
  );

  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_clk_div_cfg_arb.sv
// Bench for clk_div_cfg_arb: directed scenarios plus random requests, all
// checked every cycle against a timeline model of the divider and arbiter.
module tb_clk_div_cfg_arb;

  localparam int MAX_DIV  = 256;
  localparam int INIT_DIV = 2;
  localparam int W        = $clog2(MAX_DIV) + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] div_in0 = '0;
  logic [W-1:0] div_in1 = '0;
  logic [1:0]   ack;
  logic         err, busy, clk_div, tick;
  logic [W-1:0] cur_div;

  clk_div_cfg_arb #(.MAX_DIV(MAX_DIV), .INIT_DIV(INIT_DIV), .W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .div_in0(div_in0), .div_in1(div_in1), .ack(ack), .err(err),
    .busy(busy), .cur_div(cur_div), .clk_div(clk_div), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model: absolute edge number of the next toggle plus request bookkeeping.
  int         cyc, m_next, m_div, m_pval;
  logic       m_lvl, m_tick, m_err, m_busy, m_pend, m_pid, m_ptr;
  logic [1:0] m_ack;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    cyc = 0; m_next = INIT_DIV; m_div = INIT_DIV; m_pval = 0;
    m_lvl = 0; m_tick = 0; m_err = 0; m_busy = 0; m_pend = 0; m_pid = 0; m_ptr = 0;
    m_ack = 2'b00;
  endtask

  task automatic model_step();
    int   t, nd, v;
    logic parked, hit, g;
    cyc++;
    t      = cyc;
    parked = !enable && !m_lvl;
    hit    = !parked && (t == m_next);
    nd     = m_div;
    if (m_ack != 2'b00) begin
      m_ack = 2'b00;
      m_err = 0;
    end else if (!m_pend) begin
      if (req != 2'b00) begin
        g     = (req == 2'b11) ? m_ptr : req[1];
        m_ptr = !g;
        v     = g ? int'(div_in1) : int'(div_in0);
        if (v == 0 || v > MAX_DIV) begin
          m_ack[g] = 1'b1;
          m_err    = 1'b1;
        end else begin
          m_pend = 1; m_pid = g; m_pval = v;
        end
      end
    end else if ((hit && m_lvl) || parked) begin
      nd = m_pval;
      m_pend = 0;
      m_ack[m_pid] = 1'b1;
    end
    m_tick = hit;
    if (hit) m_lvl = !m_lvl;
    if (hit || parked) m_next = t + nd;
    m_div  = nd;
    m_busy = m_pend || (m_ack != 2'b00);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", ack, m_ack);
      check("err", err, m_err);
      check("busy", busy, m_busy);
      check("cur_div", cur_div, m_div);
      check("clk_div", clk_div, m_lvl);
      check("tick", tick, m_tick);
    end
  end

  // One clock: model advances on the edge, inputs change just after the
  // falling edge; requesters drop req as soon as their ack is seen.
  task automatic step();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic wait_ack(input int i, input int bound, output int lat);
    lat = 0;
    do begin step(); lat++; end while (!ack[i] && lat < bound);
    check($sformatf("ack%0d_seen", i), ack[i], 1);
  endtask

  task automatic wait_rise(input int bound, output int n);
    n = 0;
    do begin step(); n++; end while (!(tick && clk_div) && n < bound);
    check("rise_seen", {tick, clk_div}, 2'b11);
  endtask

  task automatic measure(output int hi, output int lo);
    int n;
    wait_rise(600, n);
    hi = 0;
    do begin hi++; step(); end while (clk_div && hi < 600);
    lo = 0;
    do begin lo++; step(); end while (!clk_div && lo < 600);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hi, lo, n, rearm;
    int order[$];
    #1;
    reset = 0; enable = 1; m_reset(); chk_en = 1;
    step(); step();
    reset = 1;

    // T1: INIT_DIV=2 -> 2 cycles high, 2 low, tick on every other edge
    for (int k = 1; k <= 8; k++) begin
      step();
      check("T1_clk_div", clk_div, (k / 2) % 2);
      check("T1_tick", tick, (k % 2 == 0));
    end

    // T2: request 5 during a high phase; applied at the following fall
    n = 0;
    do begin step(); n++; end while (!clk_div && n < 10);
    check("T2_in_high", clk_div, 1);
    div_in0 = W'(5); req[0] = 1'b1;
    wait_ack(0, 20, lat);
    check("T2_at_fall", {tick, clk_div}, 2'b10);
    check("T2_err", err, 0);
    check("T2_cur_div", cur_div, 5);
    measure(hi, lo);
    check("T2_hi", hi, 5);
    check("T2_lo", lo, 5);

    // T4: rejected values; also hands the rr pointer back to requester 0
    div_in1 = '0; req[1] = 1'b1;
    wait_ack(1, 4, lat);
    check("T4_err0", err, 1);
    check("T4_lat0_le2", lat <= 2, 1);
    check("T4_cur_div0", cur_div, 5);
    step();
    div_in1 = W'(MAX_DIV + 1); req[1] = 1'b1;
    wait_ack(1, 4, lat);
    check("T4_err257", err, 1);
    check("T4_cur_div257", cur_div, 5);
    step();

    // T3: simultaneous requests, requester 0 re-raises after its ack
    div_in0 = W'(3); div_in1 = W'(4); req = 2'b11;
    rearm = 0;
    for (int s = 0; s < 300 && order.size() < 3; s++) begin
      step();
      if (rearm == 1) begin req[0] = 1'b1; rearm = 0; end
      if (ack != 2'b00) begin
        order.push_back(ack[1] ? 1 : 0);
        check("T3_at_fall", {tick, clk_div}, 2'b10);
        if (ack[0] && order.size() == 1) rearm = 1;
      end
    end
    check("T3_nacks", order.size(), 3);
    while (order.size() < 3) order.push_back(-1);
    check("T3_order0", order[0], 0);
    check("T3_order1", order[1], 1);
    check("T3_order2", order[2], 0);
    check("T3_cur_div", cur_div, 3);

    // T5: park, load 7 while parked, then resume
    enable = 0;
    n = 0;
    do begin step(); n++; end while (clk_div && n < 20);
    step();
    div_in0 = W'(7); req[0] = 1'b1;
    wait_ack(0, 4, lat);
    check("T5_lat_le2", lat <= 2, 1);
    check("T5_cur_div", cur_div, 7);
    enable = 1;
    wait_rise(40, n);
    check("T5_first_rise", n, 7);
    measure(hi, lo);
    check("T5_period", hi + lo, 14);

    // T6: reset while a request waits for its edge
    div_in0 = W'(9); req[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!(busy && ack == 2'b00) && n < 10);
    check("T6_waiting", busy, 1);
    reset = 0; m_reset(); req = 2'b00;
    #1;
    check("T6_ack", ack, 0);
    check("T6_cur_div", cur_div, INIT_DIV);
    check("T6_clk_div", clk_div, 0);
    check("T6_busy", busy, 0);
    check("T6_tick", tick, 0);
    step(); step();
    reset = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("T6_no_ack", ack, 0);
    end

    // Random requests and enable changes
    for (int s = 0; s < 3000; s++) begin
      step();
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && !ack[i] && $urandom_range(0, 7) == 0) begin
          int r, v;
          r = $urandom_range(0, 39);
          if (r == 0)      v = 0;
          else if (r == 1) v = MAX_DIV + 1;
          else if (r == 2) v = MAX_DIV;
          else             v = $urandom_range(1, 8);
          if (i == 0) div_in0 = W'(v); else div_in1 = W'(v);
          req[i] = 1'b1;
        end
      end
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
